// File: rtl/sram_host_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_host_arbiter_if
//   Request/acknowledge bus between the host control module (OSD/SD loader)
//   and the SRAM arbiter.
//
//   master : host side   - drives host_req/host_we/host_addr/host_wdata,
//                           receives host_rdata/host_ack/host_err
//   slave  : arbiter side - the mirror image
//
//   host_req   : level request, held until host_ack
//   host_we    : 1 = write, 0 = read
//   host_addr  : byte address (top bit selects the bank the core never sees)
//   host_wdata : write data
//   host_rdata : read data, valid while host_ack = 1
//   host_ack   : one-cycle completion pulse
//   host_err   : qualifies host_ack (timeout or refused write)
// -----------------------------------------------------------------------------
interface sram_host_arbiter_if #(
    parameter int unsigned HOST_AW = 20
);
    logic               host_req;
    logic               host_we;
    logic [HOST_AW-1:0] host_addr;
    logic [7:0]         host_wdata;
    logic [7:0]         host_rdata;
    logic               host_ack;
    logic               host_err;

    modport master (
        output host_req, host_we, host_addr, host_wdata,
        input  host_rdata, host_ack, host_err
    );

    modport slave (
        input  host_req, host_we, host_addr, host_wdata,
        output host_rdata, host_ack, host_err
    );
endinterface

// File: rtl/sram_host_arbiter.sv
// -----------------------------------------------------------------------------
// sram_host_arbiter
//   Shares the external 512Kx8 SRAM between the SAM Coupe core and the host
//   control module. The core has absolute priority through a purely
//   combinational pad mux; the host is served from a small FSM only in cycles
//   the core leaves idle, with abort-and-retry and a starvation timeout.
//
//   Parameters
//     TIMEOUT : host wait limit in clk cycles before an error acknowledge
//     HOST_AW : host address width
//
//   Ports
//     clk, reset_n          : 24 MHz clock, synchronous active-low reset
//     core_cs/addr/we_n/dout: core SRAM port (core_din returns the pad data)
//     host                  : host request/acknowledge bus (slave modport)
//     sram_*                : SRAM pads
//
//   Build option
//     SRAM_ARB_HOST_WRITE_EN : when defined the host may write; otherwise a
//                              host write is refused with host_err = 1 and
//                              the host never pulls sram_we_n low.
// -----------------------------------------------------------------------------
module sram_host_arbiter #(
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned HOST_AW = 20
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      core_cs,
    input  logic [18:0]               core_addr,
    input  logic                      core_we_n,
    input  logic [7:0]                core_dout,
    output logic [7:0]                core_din,
    sram_host_arbiter_if.slave        host,
    output logic [19:0]               sram_addr,
    output logic                      sram_we_n,
    output logic                      sram_oe_n,
    output logic                      sram_ub_n,
    output logic                      sram_lb_n,
    inout  wire  [7:0]                sram_data
);

`ifdef SRAM_ARB_HOST_WRITE_EN
    localparam bit HOST_WRITE_EN = 1'b1;
`else
    localparam bit HOST_WRITE_EN = 1'b0;
`endif

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_STROBE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0] TIMEOUT_SAT  = 16'(TIMEOUT);

    logic [2:0]         state;
    logic [15:0]        wait_cnt;
    logic               timeout_q;   // error acknowledge pulse after a timeout
    logic               refuse_q;    // current request is a refused write
    logic               need_low_q;  // host_req must be seen low before a new accept
    logic [7:0]         rdata_q;
    logic [HOST_AW-1:0] haddr_q;
    logic [7:0]         hwdata_q;
    logic               hwe_q;
    logic [19:0]        last_addr_q;

    logic               accept;
    logic               host_drive;
    logic               data_oe;
    logic [7:0]         data_out;

    assign accept = (state == ST_IDLE) && host.host_req && !need_low_q;

    // Host owns the pads only in the access states, never for a refused write,
    // and never while the core is selected.
    assign host_drive = !core_cs && !refuse_q &&
                        ((state == ST_SETUP) || (state == ST_STROBE) || (state == ST_DONE));

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            timeout_q  <= 1'b0;
            refuse_q   <= 1'b0;
            need_low_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            timeout_q <= 1'b0;
            if (!host.host_req) begin
                need_low_q <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        wait_cnt <= '0;
                        if (host.host_we && !HOST_WRITE_EN) begin
                            refuse_q <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            refuse_q <= 1'b0;
                            state    <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    // Saturating so repeated aborts cannot wrap the counter.
                    if (wait_cnt != TIMEOUT_SAT) begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                    if (!core_cs) begin
                        state <= ST_SETUP;
                    end else if (wait_cnt >= TIMEOUT_LAST) begin
                        timeout_q  <= 1'b1;
                        need_low_q <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end

                ST_SETUP: begin
                    state <= core_cs ? ST_WAIT : ST_STROBE;
                end

                ST_STROBE: begin
                    if (core_cs) begin
                        state <= ST_WAIT;
                    end else begin
                        if (!hwe_q) begin
                            rdata_q <= sram_data;
                        end
                        state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // A refused write never touched the pads, so the core
                    // cannot abort it.
                    if (core_cs && !refuse_q) begin
                        state <= ST_WAIT;
                    end else begin
                        need_low_q <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: pure datapath registers carry no reset; they are always loaded
    // before any output depends on them.
    always_ff @(posedge clk) begin
        if (accept) begin
            haddr_q  <= host.host_addr;
            hwdata_q <= host.host_wdata;
            hwe_q    <= host.host_we;
        end
        last_addr_q <= sram_addr;
    end

    // -------------------------------------------------------------------------
    // Pad mux
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        sram_addr = last_addr_q;
        sram_we_n = 1'b1;
        sram_oe_n = 1'b1;
        data_oe   = 1'b0;
        data_out  = hwdata_q;

        if (core_cs) begin
            sram_addr = {1'b0, core_addr};
            sram_we_n = core_we_n;
            sram_oe_n = ~core_we_n;
            data_oe   = ~core_we_n;
            data_out  = core_dout;
        end else if (host_drive) begin
            sram_addr = 20'(haddr_q);
            if (hwe_q && HOST_WRITE_EN) begin
                // Data held across SETUP, STROBE and DONE; strobe only in STROBE.
                data_oe   = 1'b1;
                sram_we_n = (state != ST_STROBE);
            end else if (!hwe_q) begin
                sram_oe_n = (state == ST_DONE);
            end
        end
    end

    assign sram_data = data_oe ? data_out : 8'bz;
    assign core_din  = sram_data;
    assign sram_ub_n = 1'b1;
    assign sram_lb_n = 1'b0;

    // A successful acknowledge is withheld if the core aborts DONE, so the
    // host sees exactly one acknowledge per request.
    assign host.host_ack   = timeout_q || ((state == ST_DONE) && (refuse_q || !core_cs));
    assign host.host_err   = timeout_q || ((state == ST_DONE) && refuse_q);
    assign host.host_rdata = rdata_q;

endmodule

// File: doc/sram_host_arbiter.md
# sram_host_arbiter

Shares the single external 512K×8 SRAM between the SAM Coupé core and the host control module (OSD/SD loader). The core always has absolute priority and a zero-latency combinational path; the host receives cycles only when the core leaves the bus idle, through a request/acknowledge handshake with abort-and-retry and a starvation timeout. Sits between the core's SRAM port and the SRAM pad signals, ahead of the power-on config reader.

## Interface
- `TIMEOUT`, 4096: host wait limit in `clk` cycles before an error acknowledge; 1..65535.
- `HOST_AW`, 20: host address width; the upper bit selects the bank the core never reaches.
- `clk` in 1: 24 MHz SRAM clock; every register is on its rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `core_cs` in 1: the core owns the SRAM this cycle.
- `core_addr` in 19: core address, zero-extended to 20 bits.
- `core_we_n` in 1: core write strobe.
- `core_dout` in 8: core write data.
- `core_din` out 8: read data to the core; equals `sram_data` whenever `core_cs`=1.
- `host_req` in 1: host request; level, held until `host_ack`.
- `host_we` in 1: 1 = write, 0 = read.
- `host_addr` in HOST_AW: host address.
- `host_wdata` in 8: host write data.
- `host_rdata` out 8: host read data; valid while `host_ack`=1; reset 0.
- `host_ack` out 1: one-cycle completion pulse; reset 0.
- `host_err` out 1: qualifies `host_ack`; 1 = timeout or refused write; reset 0.
- `sram_addr` out 20, `sram_we_n` out 1, `sram_oe_n` out 1, `sram_ub_n` out 1, `sram_lb_n` out 1, `sram_data` inout 8: SRAM pads.

## Operation
- `sram_ub_n`=1 and `sram_lb_n`=0, constant.
- Core path: when `core_cs`=1, the pads equal the core port combinationally. `sram_addr`={1'b0,core_addr}, `sram_we_n`=core_we_n, `sram_oe_n`=~core_we_n. `sram_data` is driven with `core_dout` only when core_we_n=0 and is hi-Z otherwise. Host registers have no effect in this case.
- Host FSM states:
  - IDLE: on `host_req`=1, latch addr, wdata and we, clear the wait counter, go to WAIT.
  - WAIT: if `core_cs`=0, go to SETUP. The wait counter increments every cycle spent in WAIT. When the counter reaches TIMEOUT-1, pulse `host_ack` with `host_err`=1 and return to IDLE.
  - SETUP: drive the host address. For a read, `sram_oe_n`=0. For a write, drive the data with `sram_we_n`=1.
  - STROBE: for a write, `sram_we_n`=0. For a read, capture `sram_data` into `host_rdata` at the end of the cycle.
  - DONE: `sram_we_n`=1 and the data stays driven (write hold). Pulse `host_ack` with `host_err`=0, then go to IDLE.
- Abort: if `core_cs` rises while in SETUP, STROBE or DONE, the core takes the pads that same cycle and the FSM returns to WAIT. The wait counter is not cleared. A write that is aborted in STROBE is repeated in full.
- When `core_cs`=0 and the FSM is in IDLE or WAIT, the pads idle: we_n=1, oe_n=1, data hi-Z, and the address holds its last value.
- After `host_ack`, `host_req` must be sampled low for one cycle before a new request is accepted from IDLE. Back-to-back requests therefore cost at least 1 idle cycle.

## Timing
- Core: 0-cycle latency, purely combinational through the mux.
- Host, uncontended read or write: `host_req` rises at cycle N, `host_ack` is high at cycle N+4 (IDLE→WAIT→SETUP→STROBE→DONE).
- Error acknowledge: issued TIMEOUT cycles after the FSM enters WAIT when `core_cs` has stayed high the whole time.
- Synchronous reset (`reset_n`=0 at a rising edge): FSM to IDLE, counter 0, `host_ack`=0, `host_err`=0, `host_rdata`=0, host pad drive released. A host access in progress is dropped without an acknowledge. Core passthrough keeps working during reset.
- If `host_req` and `core_cs` rise in the same cycle, the core wins and the FSM moves to WAIT.

## Configuration
- `SRAM_ARB_HOST_WRITE_EN`:
  - Defined: host writes behave as described above.
  - Undefined: a request with `host_we`=1 goes IDLE→DONE without touching the pads, acknowledges with `host_err`=1 one cycle after acceptance, and `sram_we_n` is never driven low by the host.

## Test plan
- Uncontended host read of 0x80123 holding 0xA5 → `host_ack` at N+4, `host_rdata`=0xA5, `host_err`=0.
- Uncontended host write of 0x3C to 0x00010, then a core read of 0x00010 → the core sees 0x3C. `sram_we_n` is low exactly one cycle and the data is driven across SETUP, STROBE and DONE.
- `core_cs` asserted in the host STROBE cycle of a write → the pads switch to the core the same cycle. The host write repeats after `core_cs` falls, and exactly one `host_ack` is produced.
- `core_cs` held high, TIMEOUT=16 → `host_ack`=1 with `host_err`=1 exactly 16 cycles after entering WAIT, and the pads never show the host address.
- `reset_n` pulsed low during SETUP → the next cycle shows IDLE, the outputs at their reset values, and no `host_ack`.
- Macro undefined, host write request → `host_ack`+`host_err` one cycle after acceptance, and `sram_we_n` stays 1 throughout.
